// File: rtl/fetch_target_queue_pkg.sv
// rtl/fetch_target_queue_pkg.sv - shared widths, depth default and entry layout for the fetch target queue
package fetch_target_queue_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int FTQ_DEPTH   = 8;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic                   taken;
    } ftq_entry_t;

endpackage

// File: rtl/fetch_target_queue_ftq_ram.sv
// rtl/fetch_target_queue_ftq_ram.sv - DEPTH-entry register file, one write port, async issue and head read ports
module ftq_ram
    import fetch_target_queue_pkg::*;
#(
    parameter int DEPTH = FTQ_DEPTH,
    parameter int IDX_W = $clog2(FTQ_DEPTH)
) (
    input  logic             Clk,
    input  logic             WrEn,
    input  logic [IDX_W-1:0] WrIdx,
    input  ftq_entry_t       WrData,
    input  logic [IDX_W-1:0] IssIdx,
    output ftq_entry_t       IssData,
    input  logic [IDX_W-1:0] HeadIdx,
    output ftq_entry_t       HeadData
);

    // Storage is deliberately not reset; the pointers define what is valid.
    ftq_entry_t mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (WrEn) begin
            mem[WrIdx] <= WrData;
        end
    end

    assign IssData  = mem[IssIdx];
    assign HeadData = mem[HeadIdx];

endmodule

// File: rtl/fetch_target_queue.sv
// rtl/fetch_target_queue.sv - in-order PC buffer between the PC stage and the ICache
// Optional same-cycle enqueue-to-request bypass when FTQ_BYPASS_EN is defined.
module fetch_target_queue
    import fetch_target_queue_pkg::*;
#(
    parameter int DEPTH = FTQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic                   Clk,
    input  logic                   Rest,
    input  logic                   PcAble,
    input  logic [INST_ADDR_W-1:0] PcDate,
    input  logic                   PcPredTaken,
    output logic                   FtqFull,
    input  logic                   PreReDirAble,
    input  logic                   RobReDirAble,
    output logic                   IcFlush,
    output logic                   IcReqAble,
    output logic [INST_ADDR_W-1:0] IcReqPc,
    output logic                   IcReqTaken,
    output logic [PTR_W-2:0]       IcReqIdx,
    input  logic                   IcReqReady,
    input  logic                   IcRespAble,
    output logic [INST_ADDR_W-1:0] FtqHeadPc,
    output logic                   FtqHeadTaken
);

    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] WrPtr, IssPtr, FrPtr;
    logic             flush, enq, issue, retire;
    ftq_entry_t       wrEntry, issEntry, headEntry;

    assign flush   = PreReDirAble | RobReDirAble;
    assign IcFlush = flush;

    // Full comes from registered pointers only, so a same-cycle retire cannot unblock enqueue.
    assign FtqFull = (PTR_W'(WrPtr - FrPtr) == PTR_W'(DEPTH));
    assign enq     = PcAble & ~FtqFull & ~flush;

    assign wrEntry.pc    = PcDate;
    assign wrEntry.taken = PcPredTaken;

    ftq_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
        .Clk      (Clk),
        .WrEn     (enq),
        .WrIdx    (WrPtr[IDX_W-1:0]),
        .WrData   (wrEntry),
        .IssIdx   (IssPtr[IDX_W-1:0]),
        .IssData  (issEntry),
        .HeadIdx  (FrPtr[IDX_W-1:0]),
        .HeadData (headEntry)
    );

`ifdef FTQ_BYPASS_EN
    logic bypass;
    assign bypass     = (IssPtr == WrPtr) & enq;
    assign IcReqAble  = ((IssPtr != WrPtr) & ~flush) | bypass;
    assign IcReqPc    = bypass ? PcDate : issEntry.pc;
    assign IcReqTaken = bypass ? PcPredTaken : issEntry.taken;
`else
    assign IcReqAble  = (IssPtr != WrPtr) & ~flush;
    assign IcReqPc    = issEntry.pc;
    assign IcReqTaken = issEntry.taken;
`endif
    assign IcReqIdx = IssPtr[IDX_W-1:0];

    assign FtqHeadPc    = headEntry.pc;
    assign FtqHeadTaken = headEntry.taken;

    assign issue  = IcReqAble & IcReqReady;
    assign retire = IcRespAble & ~flush & (FrPtr != IssPtr);

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            WrPtr  <= '0;
            IssPtr <= '0;
            FrPtr  <= '0;
        end else if (flush) begin
            WrPtr  <= '0;
            IssPtr <= '0;
            FrPtr  <= '0;
        end else begin
            if (enq)    WrPtr  <= WrPtr + 1'b1;
            if (issue)  IssPtr <= IssPtr + 1'b1;
            if (retire) FrPtr  <= FrPtr + 1'b1;
        end
    end

    // A response with nothing issued is an ICache protocol violation; it is dropped above.
    assert property (@(posedge Clk) disable iff (!Rest)
        !(IcRespAble && !flush && (FrPtr == IssPtr)));

endmodule

// File: tb/tb_fetch_target_queue.sv
// tb/tb_fetch_target_queue.sv - scoreboard bench for fetch_target_queue
module tb_fetch_target_queue;

`ifdef FTQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rest = 1'b0;
    logic        PcAble = 1'b0;
    logic [31:0] PcDate = '0;
    logic        PcPredTaken = 1'b0;
    logic        FtqFull;
    logic        PreReDirAble = 1'b0;
    logic        RobReDirAble = 1'b0;
    logic        IcFlush;
    logic        IcReqAble;
    logic [31:0] IcReqPc;
    logic        IcReqTaken;
    logic [2:0]  IcReqIdx;
    logic        IcReqReady = 1'b0;
    logic        IcRespAble = 1'b0;
    logic [31:0] FtqHeadPc;
    logic        FtqHeadTaken;

    fetch_target_queue #(.DEPTH(8)) dut (
        .Clk          (Clk),
        .Rest         (Rest),
        .PcAble       (PcAble),
        .PcDate       (PcDate),
        .PcPredTaken  (PcPredTaken),
        .FtqFull      (FtqFull),
        .PreReDirAble (PreReDirAble),
        .RobReDirAble (RobReDirAble),
        .IcFlush      (IcFlush),
        .IcReqAble    (IcReqAble),
        .IcReqPc      (IcReqPc),
        .IcReqTaken   (IcReqTaken),
        .IcReqIdx     (IcReqIdx),
        .IcReqReady   (IcReqReady),
        .IcRespAble   (IcRespAble),
        .FtqHeadPc    (FtqHeadPc),
        .FtqHeadTaken (FtqHeadTaken)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic [2:0]  idx;
    } req_t;

    req_t        expQ[$];
    logic [31:0] headQ[$];
    int          errors = 0;
    int          checks = 0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic void expIssue(logic [31:0] pc, logic tk, logic [2:0] idx);
        req_t r;
        r.pc = pc; r.tk = tk; r.idx = idx;
        expQ.push_back(r);
    endfunction

    // Monitor: every accepted request and every retire is compared against the scoreboard.
    always @(negedge Clk) begin
        req_t e;
        if (Rest && IcReqAble && IcReqReady) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL issue_unexpected actual=%h expected=none", IcReqPc);
            end else begin
                e = expQ.pop_front();
                check("issue_pc", IcReqPc, e.pc);
                check("issue_taken", 32'(IcReqTaken), 32'(e.tk));
                check("issue_idx", 32'(IcReqIdx), 32'(e.idx));
            end
        end
        if (Rest && IcRespAble && !PreReDirAble && !RobReDirAble) begin
            if (headQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL head_unexpected actual=%h expected=none", FtqHeadPc);
            end else begin
                check("head_pc", FtqHeadPc, headQ.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step();
        check("rst_full", 32'(FtqFull), 0);
        check("rst_reqable", 32'(IcReqAble), 0);
        check("rst_flush", 32'(IcFlush), 0);
        step();
        Rest = 1'b1;
        step();

        // Three PCs issued in order, one per cycle
        IcReqReady = 1'b1;
        expIssue(32'h1c000000, 1'b0, 3'd0);
        expIssue(32'h1c000010, 1'b1, 3'd1);
        expIssue(32'h1c000020, 1'b0, 3'd2);
        PcAble = 1'b1; PcDate = 32'h1c000000; PcPredTaken = 1'b0;
        #1 check("latency_first", 32'(IcReqAble), 32'(BYP));
        step();
        PcDate = 32'h1c000010; PcPredTaken = 1'b1;
        #1 check("latency_second", 32'(IcReqAble), 1);
        step();
        PcDate = 32'h1c000020; PcPredTaken = 1'b0;
        step();
        PcAble = 1'b0;
        step();
        step();
        IcReqReady = 1'b0;
        for (int i = 0; i < 3; i++) headQ.push_back(32'h1c000000 + 32'(i) * 32'h10);
        IcRespAble = 1'b1;
        repeat (3) step();
        IcRespAble = 1'b0;

        // Fill with IcReqReady low; the 9th PC is refused
        for (int i = 0; i < 8; i++) begin
            PcAble = 1'b1; PcDate = 32'h1c001000 + 32'(i) * 4; PcPredTaken = i[0];
            expIssue(PcDate, PcPredTaken, 3'((3 + i) % 8));
            step();
        end
        check("full_after_8", 32'(FtqFull), 1);
        PcDate = 32'h1c00dead; PcPredTaken = 1'b0;
        step();
        PcAble = 1'b0;
        check("full_after_9th", 32'(FtqFull), 1);
        check("head_oldest", FtqHeadPc, 32'h1c001000);

        // Issue all, then retire and enqueue in the same cycle
        IcReqReady = 1'b1;
        repeat (8) step();
        IcReqReady = 1'b0;
        check("full_issued", 32'(FtqFull), 1);
        check("all_issued", 32'(IcReqAble), 0);
        headQ.push_back(32'h1c001000);
        IcRespAble = 1'b1; PcAble = 1'b1; PcDate = 32'h1c002000; PcPredTaken = 1'b0;
        step();
        IcRespAble = 1'b0;
        check("refused_when_full", 32'(FtqFull), 0);
        check("head_advanced", FtqHeadPc, 32'h1c001004);
        expIssue(32'h1c002000, 1'b0, 3'd3);
        step();
        PcAble = 1'b0;
        check("accepted_next", 32'(FtqFull), 1);
        IcReqReady = 1'b1;
        step();
        IcReqReady = 1'b0;

        // Retire 3, leaving 5 outstanding plus one pending issue, then ROB redirect
        headQ.push_back(32'h1c001004);
        headQ.push_back(32'h1c001008);
        headQ.push_back(32'h1c00100c);
        IcRespAble = 1'b1;
        repeat (3) step();
        IcRespAble = 1'b0;
        PcAble = 1'b1; PcDate = 32'h1c003000;
        step();
        PcAble = 1'b0;
        check("pending_before_flush", 32'(IcReqAble), 1);
        RobReDirAble = 1'b1; IcReqReady = 1'b1;
        #1 check("rob_icflush", 32'(IcFlush), 1);
        check("rob_reqable_low", 32'(IcReqAble), 0);
        step();
        RobReDirAble = 1'b0;
        check("post_flush_full", 32'(FtqFull), 0);
        check("post_flush_empty", 32'(IcReqAble), 0);
        check("post_flush_idx", 32'(IcReqIdx), 0);
        expIssue(32'h1c000100, 1'b0, 3'd0);
        PcAble = 1'b1; PcDate = 32'h1c000100;
        step();
        PcAble = 1'b0;
        step();
        headQ.push_back(32'h1c000100);
        IcRespAble = 1'b1;
        step();
        IcRespAble = 1'b0;

        // Both redirects together with enqueue and response
        expIssue(32'h1c000200, 1'b1, 3'd1);
        expIssue(32'h1c000210, 1'b0, 3'd2);
        PcAble = 1'b1; PcDate = 32'h1c000200; PcPredTaken = 1'b1;
        step();
        PcDate = 32'h1c000210; PcPredTaken = 1'b0;
        step();
        PcAble = 1'b0;
        step();
        PreReDirAble = 1'b1; RobReDirAble = 1'b1; IcRespAble = 1'b1;
        PcAble = 1'b1; PcDate = 32'h1c0bad00;
        #1 check("dual_icflush", 32'(IcFlush), 1);
        step();
        PreReDirAble = 1'b0; RobReDirAble = 1'b0; IcRespAble = 1'b0; PcAble = 1'b0;
        check("dual_enq_dropped", 32'(IcReqAble), 0);
        check("dual_full", 32'(FtqFull), 0);
        check("dual_idx", 32'(IcReqIdx), 0);
        expIssue(32'h1c000300, 1'b0, 3'd0);
        PcAble = 1'b1; PcDate = 32'h1c000300;
        step();
        PcAble = 1'b0;
        step();
        headQ.push_back(32'h1c000300);
        IcRespAble = 1'b1;
        step();
        IcRespAble = 1'b0;

        // Stream 20 PCs across the pointer wrap, retiring two cycles behind
        for (int i = 0; i < 20; i++) begin
            PcAble = 1'b1; PcDate = 32'h1c010000 + 32'(i) * 32'h10; PcPredTaken = i[0];
            expIssue(PcDate, PcPredTaken, 3'((1 + i) % 8));
            IcRespAble = (i >= 2);
            if (i >= 2) headQ.push_back(32'h1c010000 + 32'(i - 2) * 32'h10);
            #1 check("wrap_no_full", 32'(FtqFull), 0);
            step();
        end
        PcAble = 1'b0;
        for (int i = 18; i < 20; i++) begin
            headQ.push_back(32'h1c010000 + 32'(i) * 32'h10);
            IcRespAble = 1'b1;
            step();
        end
        IcRespAble = 1'b0; IcReqReady = 1'b0;
        step();
        check("wrap_drained", 32'(IcReqAble), 0);
        check("issue_queue_empty", 32'(expQ.size()), 0);
        check("head_queue_empty", 32'(headQ.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_target_queue.md
# fetch_target_queue

Fetch target queue between the BPU program counter stage and the ICache. Each valid PC from the PC stage is buffered in order with its prediction tag, issued to the ICache under a ready/valid handshake, and held until the ICache returns that fetch block. The oldest PC is returned to predecode. Redirects from predecode or the ROB flush the whole queue, and a full queue back-pressures the PC stage through the stop path.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- PTR_W, log2(DEPTH)+1, pointer width including the wrap bit.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rest  in  1  reset, asynchronous, active-low.
- PcAble  in  1  PC stage output valid.
- PcDate  in  `InstAddrBus  PC to enqueue.
- PcPredTaken  in  1  set when PcDate came from a BTB-taken prediction.
- FtqFull  out  1  queue full; ORed into PcStop by ctrl.
- PreReDirAble  in  1  predecode redirect; flushes the queue.
- RobReDirAble  in  1  ROB redirect; flushes the queue.
- IcFlush  out  1  flush indication to the ICache; equals PreReDirAble | RobReDirAble, combinational.
- IcReqAble  out  1  ICache request valid.
- IcReqPc  out  `InstAddrBus  request PC.
- IcReqTaken  out  1  prediction tag of the request.
- IcReqIdx  out  log2(DEPTH)  queue slot of the request.
- IcReqReady  in  1  ICache accepts the request.
- IcRespAble  in  1  ICache returns the oldest outstanding fetch block, in order.
- FtqHeadPc  out  `InstAddrBus  PC of the oldest issued entry, for predecode.
- FtqHeadTaken  out  1  tag of the oldest issued entry.

## Operation
- Three PTR_W pointers: WrPtr (enqueue), IssPtr (next to issue), FrPtr (oldest outstanding). Slot index is ptr[PTR_W-2:0]. The wrap bit distinguishes full from empty.
- Occupancy = WrPtr - FrPtr, modulo 2^PTR_W.
- FtqFull = (occupancy == DEPTH), decoded from registered pointers only.
- **Enqueue:** when PcAble & !FtqFull & !flush, write {PcDate, PcPredTaken} at WrPtr and increment WrPtr.
- **Issue:** IcReqAble = (IssPtr != WrPtr) & !flush. IcReqPc, IcReqTaken and IcReqIdx come from the IssPtr slot. IssPtr increments on IcReqAble & IcReqReady.
- **Retire:** on IcRespAble & !flush with FrPtr != IssPtr, FrPtr increments. FtqHeadPc and FtqHeadTaken read the FrPtr slot.
- IcRespAble while FrPtr == IssPtr is a protocol error. It is ignored, and an assertion fires in simulation.
- **Flush:** when PreReDirAble | RobReDirAble, all three pointers go to 0 on the next edge. The enqueue, issue handshake and retire of that cycle are discarded. On IcFlush, the ICache drops every outstanding response.
- Enqueue, issue and retire may all occur in the same cycle. Each pointer updates independently.
- When full, enqueue stays blocked even if a retire happens in the same cycle. This is because full is decoded from registered pointers.

## Timing
- Reset values: pointers 0, FtqFull 0, IcReqAble 0. IcReqPc, IcReqTaken, FtqHeadPc and FtqHeadTaken read slot 0; storage is not reset, so their values are don't-care. IcFlush follows its inputs.
- Enqueue-to-IcReqAble latency is 1 cycle without bypass.
- Flush asserted in cycle N forces IcReqAble to 0 in cycle N. The queue is empty from cycle N+1, and a PC presented in N+1 is accepted.
- Reset asserted mid-operation clears the pointers immediately, without waiting for a clock edge.
- IcReqAble, once raised, holds its PC stable until IcReqReady or a flush.

## Configuration
- FTQ_BYPASS_EN defined: when IssPtr == WrPtr and PcAble & !FtqFull & !flush, the request is driven straight from the inputs in the same cycle:
  - IcReqAble = 1, IcReqPc = PcDate, IcReqTaken = PcPredTaken.
  - The entry is still written.
  - If IcReqReady is also high, WrPtr and IssPtr both increment.
- FTQ_BYPASS_EN undefined: no bypass; 1-cycle latency always applies.

## Structure
- InstAddrBus, AbleValue, EnableValue and a new FtqDepth default are defined in define.v.
- A single sub-module, ftq_ram: a DEPTH x (addr+1) register file with one write port and two asynchronous read ports (issue, head).
- Pointer logic and the handshake stay in the top module.

## Test plan
- Reset, then 3 PCs 0x1c000000, 0x1c000010, 0x1c000020 with IcReqReady=1 -> issued in order, one per cycle, starting the cycle after the first enqueue (same cycle with FTQ_BYPASS_EN).
- IcReqReady=0, 8 PCs enqueued -> FtqFull=1 after the 8th; the 9th is not accepted; one IcRespAble does not free a slot because nothing has issued.
- Fill the queue, issue all, then one IcRespAble and PcAble in the same cycle -> PcAble is refused (full is registered); accepted the next cycle; FtqHeadPc advances to entry 1.
- RobReDirAble with 5 entries outstanding -> IcFlush=1 and IcReqAble=0 in the same cycle; next cycle pointers are 0 and FtqFull=0; new PC 0x1c000100 issues as slot 0.
- PreReDirAble and RobReDirAble together with enqueue and IcRespAble -> single flush; enqueue and retire discarded.
- Pointer wrap: stream 20 PCs through a DEPTH=8 queue -> no false full or empty; order is preserved across the wrap.
